// File: rtl/nes_clken_gen.sv
// Multi-channel NCO clock-enable generator: one phase accumulator per channel, carry-out becomes a one-cycle ce strobe.
// Optional macro NESCLK_REALIGN_EN builds the realign clear; without it the realign port is ignored.
module nes_clken_gen #(
    parameter int                        NUM_CH      = 2,
    parameter int                        ACC_W       = 32,
    parameter logic [NUM_CH*ACC_W-1:0]   INC_RST     = {32'd153744310, 32'd461232930},
    parameter int                        LOCK_CYCLES = 1024
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              wr_en,
    input  logic [2:0]        wr_ch,
    input  logic [ACC_W-1:0]  wr_inc,
    input  logic              realign,
    output logic [NUM_CH-1:0] ce,
    output logic              locked
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic {
        ST_SETTLE,
        ST_LOCKED
    } lock_state_e;

    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];
    logic [ACC_W-1:0]  inc_q [NUM_CH];
    logic [ACC_W-1:0]  inc_d [NUM_CH];
    logic [ACC_W:0]    sum   [NUM_CH];
    logic [NUM_CH-1:0] ce_q;
    logic [NUM_CH-1:0] ce_d;
    logic              wr_valid;

    lock_state_e       state_q;
    lock_state_e       state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    // Writes to channel indices beyond NUM_CH are dropped and do not disturb the lock FSM.
    assign wr_valid = wr_en && ({1'b0, wr_ch} < 4'(NUM_CH));

    always_comb begin
        ce_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i]   = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
            acc_d[i] = sum[i][ACC_W-1:0];
            ce_d[i]  = sum[i][ACC_W] & ch_en[i];
            inc_d[i] = (wr_en && (wr_ch == 3'(i))) ? wr_inc : inc_q[i];
        end
`ifdef NESCLK_REALIGN_EN
        if (realign) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_d[i] = '0;
            end
            ce_d = '0;
        end
`endif
    end

`ifndef NESCLK_REALIGN_EN
    logic unused_realign;
    assign unused_realign = realign;
`endif

    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                inc_q[i] <= INC_RST[i*ACC_W +: ACC_W];
            end
            ce_q <= '0;
        end else begin
            acc_q <= acc_d;
            inc_q <= inc_d;
            ce_q  <= ce_d;
        end
    end

    assign ce = ce_q;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= ST_SETTLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any valid write restarts the settle window, whether still settling or already locked.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SETTLE: begin
                if (wr_valid) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOCKED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (wr_valid) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        locked = (state_q == ST_LOCKED);
    end

endmodule
